// File: rtl/clock_display_pkg.sv
// Shared constants for the six-digit HH:MM:SS multiplexed display: digit/field
// mapping, segment codes and the blink-enable bit layout.
package clock_display_pkg;

    localparam int NUM_DIGITS = 6;

    typedef enum logic [1:0] {
        FLD_SEC = 2'd0,
        FLD_MIN = 2'd1,
        FLD_HR  = 2'd2
    } field_e;

    localparam int BLINK_SEC_BIT = 0;
    localparam int BLINK_MIN_BIT = 1;
    localparam int BLINK_HR_BIT  = 2;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    localparam logic [3:0] VAL_DASH = 4'hF;

    localparam logic [5:0] HR_MAX  = 6'd23;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [5:0] SEC_MAX = 6'd59;

    // Digits are paired ones/tens per field, seconds in the lowest slots
    function automatic field_e digit_field(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: return FLD_SEC;
            3'd2, 3'd3: return FLD_MIN;
            default:    return FLD_HR;
        endcase
    endfunction

    function automatic logic [3:0] split_digit(input logic [5:0] v, input logic tens);
        logic [5:0] q;
        logic [5:0] r;
        q = v / 6'd10;
        r = v - q * 6'd10;
        return tens ? q[3:0] : r[3:0];
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational 4-bit value to seven-segment code; anything 10 and above is a dash.
module seg7_encode
    import clock_display_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (val_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed HH:MM:SS scanner with frame-aligned input shadowing
// and per-field blinking.
module clock_display_scan
    import clock_display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_hr,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic [2:0] i_blink,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic [5:0] o_an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    DIG_LAST   = 3'(NUM_DIGITS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    dig_q, dig_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;
    logic          cap_q;
    logic [4:0]    shd_hr_q, shd_hr_d;
    logic [5:0]    shd_min_q, shd_min_d;
    logic [5:0]    shd_sec_q, shd_sec_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [5:0]    an_q, an_d;

    logic          tick;
    logic          frame_end;
    field_e        fld;
    logic [5:0]    fld_val;
    logic          fld_ok;
    logic          blink_en;
    logic          blank;
    logic [3:0]    enc_val;
    logic [6:0]    enc_seg;

    assign tick      = (presc_q == PRESC_LAST);
    assign frame_end = tick && (dig_q == DIG_LAST);

    // The capture cycle after reset holds the scan so slot 0 gets a full period
    always_comb begin
        presc_d   = presc_q;
        dig_d     = dig_q;
        frame_d   = frame_q;
        phase_d   = phase_q;
        shd_hr_d  = shd_hr_q;
        shd_min_d = shd_min_q;
        shd_sec_d = shd_sec_q;
        if (cap_q || frame_end) begin
            shd_hr_d  = i_hr;
            shd_min_d = i_min;
            shd_sec_d = i_sec;
        end
        if (!cap_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                dig_d = (dig_q == DIG_LAST) ? 3'd0 : dig_q + 3'd1;
            end
            if (frame_end) begin
                if (frame_q == FRAME_LAST) begin
                    frame_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    frame_d = frame_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        fld      = digit_field(dig_q);
        fld_val  = shd_sec_q;
        fld_ok   = (shd_sec_q <= SEC_MAX);
        blink_en = i_blink[BLINK_SEC_BIT];
        case (fld)
            FLD_MIN: begin
                fld_val  = shd_min_q;
                fld_ok   = (shd_min_q <= MIN_MAX);
                blink_en = i_blink[BLINK_MIN_BIT];
            end
            FLD_HR: begin
                fld_val  = {1'b0, shd_hr_q};
                fld_ok   = ({1'b0, shd_hr_q} <= HR_MAX);
                blink_en = i_blink[BLINK_HR_BIT];
            end
            default: ;
        endcase
        enc_val = fld_ok ? split_digit(fld_val, dig_q[0]) : VAL_DASH;
        blank   = phase_q && blink_en;
    end

    seg7_encode u_enc (
        .val_i (enc_val),
        .seg_o (enc_seg)
    );

    assign seg_d = enc_seg;
    assign an_d  = blank ? 6'b000000 : (6'b000001 << dig_q);
    assign dp_d  = !blank && ((dig_q == 3'd2) || (dig_q == 3'd4));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_q   <= '0;
            dig_q     <= '0;
            frame_q   <= '0;
            phase_q   <= 1'b0;
            cap_q     <= 1'b1;
            shd_hr_q  <= '0;
            shd_min_q <= '0;
            shd_sec_q <= '0;
            seg_q     <= '0;
            dp_q      <= 1'b0;
            an_q      <= '0;
        end else begin
            presc_q   <= presc_d;
            dig_q     <= dig_d;
            frame_q   <= frame_d;
            phase_q   <= phase_d;
            cap_q     <= 1'b0;
            shd_hr_q  <= shd_hr_d;
            shd_min_q <= shd_min_d;
            shd_sec_q <= shd_sec_d;
            // Outputs stay dark until the shadow holds real data
            if (cap_q) begin
                seg_q <= '0;
                dp_q  <= 1'b0;
                an_q  <= '0;
            end else begin
                seg_q <= seg_d;
                dp_q  <= dp_d;
                an_q  <= an_d;
            end
        end
    end

    assign o_seg = seg_q;
    assign o_dp  = dp_q;
    assign o_an  = an_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench: stimulus queues expected outputs tagged with the cycle they
// are due; an independent monitor pops and compares them at the falling edge.
module tb_clock_display_scan;

    localparam int SD = 4;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] hr = '0;
    logic [5:0] mn = '0;
    logic [5:0] sc = '0;
    logic [2:0] blink = '0;
    logic [6:0] o_seg;
    logic       o_dp;
    logic [5:0] o_an;

    clock_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_hr    (hr),
        .i_min   (mn),
        .i_sec   (sc),
        .i_blink (blink),
        .o_seg   (o_seg),
        .o_dp    (o_dp),
        .o_an    (o_an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         tag;
        logic [5:0] an;
        logic       dp;
        logic [6:0] seg;
        logic       care;
    } exp_t;

    exp_t sb[$];
    int   cyc_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
                e = sb.pop_front();
                vectors++;
                if (e.cyc != cyc_cnt || o_an !== e.an || o_dp !== e.dp ||
                    (e.care && o_seg !== e.seg)) begin
                    miscompares++;
                    $display("FAIL vec%0d cyc%0d: got an=%b dp=%b seg=%b, want an=%b dp=%b seg=%b (due cyc%0d)",
                             e.tag, cyc_cnt, o_an, o_dp, o_seg, e.an, e.dp, e.seg, e.cyc);
                end
            end
        end
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    function automatic void push(input int cyc, input int tag, input logic [5:0] an,
                                 input logic dp, input logic [6:0] seg, input logic care);
        exp_t e;
        e.cyc = cyc; e.tag = tag; e.an = an; e.dp = dp; e.seg = seg; e.care = care;
        sb.push_back(e);
    endfunction

    // One frame of six slots; slot d is sampled 4*d cycles after base
    function automatic void push_frame(input int base, input int tag, input int h,
                                       input int m, input int s, input logic [5:0] blank);
        int v, lim;
        logic [6:0] sg;
        for (int d = 0; d < 6; d++) begin
            v   = (d < 2) ? s : (d < 4) ? m : h;
            lim = (d >= 4) ? 23 : 59;
            sg  = (v > lim) ? 7'b1000000 : seg_of((d % 2 == 1) ? v / 10 : v % 10);
            push(base + 4 * d, tag + d, blank[d] ? 6'b000000 : 6'(1 << d),
                 !blank[d] && (d == 2 || d == 4), sg, !blank[d]);
        end
    endfunction

    task automatic start_phase(input int h, input int m, input int s, input logic [2:0] b);
        @(negedge clk);
        rst = 1'b1; hr = 5'(h); mn = 6'(m); sc = 6'(s); blink = b;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_state(input int tag);
        if (o_an !== 6'b000000 || o_dp !== 1'b0 || o_seg !== 7'b0000000) begin
            miscompares++;
            $display("FAIL rst%0d cyc%0d: got an=%b dp=%b seg=%b, want all zero",
                     tag, cyc_cnt, o_an, o_dp, o_seg);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc_cnt < target) @(negedge clk);
        @(negedge clk);
    endtask

    logic [6:0] lit_seg [6];
    int c0;
    int c1;

    initial begin
        lit_seg[0] = 7'b1111101; lit_seg[1] = 7'b1101101; lit_seg[2] = 7'b1100110;
        lit_seg[3] = 7'b1001111; lit_seg[4] = 7'b1011011; lit_seg[5] = 7'b0000110;

        // Reset state, then 12:34:56 scan with hand-written codes
        start_phase(12, 34, 56, 3'b000);
        check_reset_state(1);
        push(cyc_cnt + 1, 100, 6'b000000, 1'b0, 7'b0000000, 1'b1);
        @(negedge clk);
        c0 = cyc_cnt;
        for (int d = 0; d < 6; d++)
            push(c0 + 3 + 4 * d, 110 + d, 6'(1 << d), (d == 2 || d == 4), lit_seg[d], 1'b1);
        push_frame(c0 + 27, 120, 12, 34, 56, 6'b0);
        rst = 1'b0;
        wait_cyc(c0 + 48);

        // Mid-frame input change is held off until the next frame
        start_phase(12, 34, 59, 3'b000);
        c0 = cyc_cnt;
        push_frame(c0 + 3, 200, 12, 34, 59, 6'b0);
        push_frame(c0 + 27, 210, 12, 35, 0, 6'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        mn = 6'd35; sc = 6'd0;
        wait_cyc(c0 + 51);

        // Out-of-range hours
        start_phase(24, 7, 45, 3'b000);
        c0 = cyc_cnt;
        push_frame(c0 + 3, 300, 24, 7, 45, 6'b0);
        rst = 1'b0;
        wait_cyc(c0 + 27);

        // Seconds at 59, then 60 from the next frame
        start_phase(0, 0, 59, 3'b000);
        c0 = cyc_cnt;
        push_frame(c0 + 3, 400, 0, 0, 59, 6'b0);
        push_frame(c0 + 27, 410, 0, 0, 60, 6'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        sc = 6'd60;
        wait_cyc(c0 + 51);

        // Minute blinking over six frames
        start_phase(12, 34, 56, 3'b010);
        c0 = cyc_cnt;
        for (int f = 0; f < 6; f++)
            push_frame(c0 + 3 + 24 * f, 500 + 10 * f, 12, 34, 56,
                       (f == 2 || f == 3) ? 6'b001100 : 6'b000000);
        rst = 1'b0;
        wait_cyc(c0 + 3 + 24 * 6);

        // One-cycle reset while digit 3 is showing
        start_phase(12, 34, 56, 3'b000);
        check_reset_state(2);
        c0 = cyc_cnt;
        rst = 1'b0;
        while (cyc_cnt < c0 + 14) @(negedge clk);
        push(cyc_cnt + 1, 600, 6'b001000, 1'b0, seg_of(3), 1'b1);
        @(negedge clk);
        rst = 1'b1;
        push(cyc_cnt + 1, 601, 6'b000000, 1'b0, 7'b0000000, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        c1 = cyc_cnt;
        push(c1 + 2, 602, 6'b000001, 1'b0, seg_of(6), 1'b1);
        push_frame(c1 + 3, 610, 12, 34, 56, 6'b0);
        wait_cyc(c1 + 27);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL: %0d expected vectors never compared (first due cyc%0d, tag %0d)",
                     sb.size(), sb[0].cyc, sb[0].tag);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_display_scan.md
CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles per digit slot; legal range 2 or greater.
REQ-002 Parameter BLINK_FRAMES, default 64: full 6-digit frames per blink half-period; legal range 1 or greater.
REQ-003 Port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port i_rst  input  1  reset, synchronous, active-high.
REQ-005 Port i_hr  input  5  hours, binary; legal range 0..23.
REQ-006 Port i_min  input  6  minutes, binary; legal range 0..59.
REQ-007 Port i_sec  input  6  seconds, binary; legal range 0..59.
REQ-008 Port i_blink  input  3  field blink enables: bit 2 hours, bit 1 minutes, bit 0 seconds.
REQ-009 Port o_seg  output  7  segments, active-high, bit order {g,f,e,d,c,b,a}.
REQ-010 Port o_dp  output  1  decimal point, active-high.
REQ-011 Port o_an  output  6  digit enables, one-hot or all-zero, active-high; bit 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hr ones, 5 hr tens.

Function
REQ-012 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; a tick is asserted when the count equals SCAN_DIV-1.
REQ-013 On each tick the digit index SHALL advance 0,1,2,3,4,5 and wrap from 5 to 0; the wrap 5->0 is a frame boundary.
REQ-014 Shadow registers SHALL capture i_hr, i_min and i_sec only at a frame boundary and in the first cycle after i_rst deasserts; input changes at any other time SHALL NOT affect the display until the next capture.
REQ-015 Each field SHALL be shown as tens = value/10 and ones = value%10, with no leading-zero blanking.
REQ-016 An out-of-range shadow field (hr>23, min>59, sec>59) SHALL display dash (7'b1000000) on both of its digits.
REQ-017 Digit codes SHALL be: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-018 o_seg, o_dp and o_an SHALL be registered and SHALL reflect a new digit index one cycle after that index changes.
REQ-019 o_dp SHALL be 1 exactly when digit 2 or digit 4 is active, and 0 otherwise.
REQ-020 A frame counter SHALL count frame boundaries 0..BLINK_FRAMES-1 and wrap; on each wrap it SHALL toggle the blink phase.
REQ-021 When the blink phase is 1 and the i_blink bit for the active digit's field is 1, o_an and o_dp SHALL be 0 for that slot; o_seg is don't-care for that slot.
REQ-022 i_blink SHALL be sampled every cycle and is not shadowed.

Reset
REQ-023 While i_rst=1: prescaler=0, digit index=0, frame counter=0, blink phase=0, shadow=0, o_seg=0, o_dp=0, o_an=0.
REQ-024 In the first cycle after release the block SHALL capture inputs; in the following cycle o_an=000001 with o_seg showing the captured sec ones.
REQ-025 Reset asserted mid-frame SHALL take effect at the next edge, with no completion of the current slot.

Structure
REQ-026 Package clock_display_pkg SHALL hold: NUM_DIGITS=6, the digit-to-field mapping, segment constants for 0-9 and dash, and the field bit positions of i_blink.
REQ-027 One combinational sub-module, seg7_encode, SHALL map a 4-bit value to o_seg code, returning dash for any value of 10 or greater.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-028 Reset release, hold 12:34:56 -> o_an steps 000001..100000 every 4 cycles showing 6,5,4,3,2,1 (o_seg 1111101,1101101,1100110,1001111,1011011,0000110); o_dp=1 only at 000100 and 010000.
REQ-029 Mid-frame change 12:34:59 -> 12:35:00 at digit 2 -> current frame keeps 34:59; next frame shows 35:00.
REQ-030 i_hr=24 -> digits 5 and 4 show 1000000; minute and second digits unaffected.
REQ-031 i_blink=010 -> o_an bits 2 and 3 stay 0 for frames 2-3, then normal for frames 4-5, repeating; other digits are unaffected.
REQ-032 Assert i_rst for one cycle while digit 3 is active -> next cycle all outputs 0; after release o_an=000001 within 2 cycles.
REQ-033 i_sec=59 -> sec ones shows 1101111 and sec tens shows 1101101; i_sec=60 -> both sec digits show 1000000.
